// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential W-bit ALU with a persistent carry flag, registered
//                results, a valid/ready handshake, and iterative shift-by-N
//                and unsigned W x W multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int W  = 8,
    parameter int SW = $clog2(W) + 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   ALUOp,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic [W-1:0] rslt_hi,
    output logic         carry,
    output logic         branchFlag
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_XOR  = 4'b0001;
    localparam logic [3:0] c_OP_OR   = 4'b0010;
    localparam logic [3:0] c_OP_SHL1 = 4'b0011;
    localparam logic [3:0] c_OP_SHR1 = 4'b0100;
    localparam logic [3:0] c_OP_ADD  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_LT   = 4'b0111;
    localparam logic [3:0] c_OP_GT   = 4'b1000;
    localparam logic [3:0] c_OP_EQ   = 4'b1001;
    localparam logic [3:0] c_OP_SHLN = 4'b1010;
    localparam logic [3:0] c_OP_SHRN = 4'b1011;
    localparam logic [3:0] c_OP_MUL  = 4'b1100;
    localparam logic [3:0] c_OP_CLC  = 4'b1101;
    localparam logic [3:0] c_OP_SEC  = 4'b1110;

    logic [1:0]    r_state, w_state_nxt;
    logic [3:0]    r_op, w_op_nxt;
    logic [W-1:0]  r_a, w_a_nxt;          // shift working value / multiplicand
    logic [W-1:0]  r_b, w_b_nxt;          // multiplier, becomes product low half
    logic [W-1:0]  r_acc_hi, w_acc_hi_nxt;
    logic [SW-1:0] r_cnt, w_cnt_nxt;
    logic          r_shc, w_shc_nxt;      // intermediate shift carry, kept off the port
    logic [W-1:0]  r_rslt, w_rslt_nxt;
    logic [W-1:0]  r_rslt_hi, w_rslt_hi_nxt;
    logic          r_carry, w_carry_nxt;
    logic          r_branch, w_branch_nxt;

    logic [W:0]    w_sum_add, w_sum_sub, w_mul_sum;
    logic [SW-1:0] w_n;
    logic [W-1:0]  w_sc_rslt;
    logic          w_sc_carry, w_sc_branch, w_go_busy;
    logic [W-1:0]  w_step_a;
    logic          w_step_c;

    assign w_sum_add = {1'b0, inA} + {1'b0, inB}  + {{W{1'b0}}, r_carry};
    assign w_sum_sub = {1'b0, inA} + {1'b0, ~inB} + {{W{1'b0}}, r_carry};
    assign w_n = (inB[SW-1:0] > SW'(W)) ? SW'(W) : inB[SW-1:0];
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_b[0] ? {1'b0, r_a} : {(W+1){1'b0}});

    // Single-cycle result, evaluated against the operands presented at acceptance
    always_comb begin
        w_sc_rslt   = inA;
        w_sc_carry  = r_carry;
        w_sc_branch = 1'b0;
        w_go_busy   = 1'b0;
        case (ALUOp)
            c_OP_AND:  w_sc_rslt = inA & inB;
            c_OP_XOR:  w_sc_rslt = inA ^ inB;
            c_OP_OR:   w_sc_rslt = inA | inB;
            c_OP_SHL1: {w_sc_carry, w_sc_rslt} = {inA, r_carry};
            c_OP_SHR1: {w_sc_rslt, w_sc_carry} = {r_carry, inA};
            c_OP_ADD:  {w_sc_carry, w_sc_rslt} = w_sum_add;
            c_OP_SUB:  {w_sc_carry, w_sc_rslt} = w_sum_sub;
            c_OP_LT: begin
                w_sc_rslt   = '0;
                w_sc_branch = (inA < inB);
            end
            c_OP_GT: begin
                w_sc_rslt   = '0;
                w_sc_branch = (inA > inB);
            end
            c_OP_EQ: begin
                w_sc_rslt   = '0;
                w_sc_branch = (inA == inB);
            end
            c_OP_SHLN, c_OP_SHRN: w_go_busy = (w_n != '0);
            c_OP_MUL:  w_go_busy = 1'b1;
            c_OP_CLC:  w_sc_carry = 1'b0;
            c_OP_SEC:  w_sc_carry = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_step_a = r_a;
        w_step_c = r_shc;
        if (r_op == c_OP_SHRN) begin
            w_step_a = r_a >> 1;
            w_step_c = r_a[0];
        end else begin
            w_step_a = r_a << 1;
            w_step_c = r_a[W-1];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_acc_hi_nxt  = r_acc_hi;
        w_cnt_nxt     = r_cnt;
        w_shc_nxt     = r_shc;
        w_rslt_nxt    = r_rslt;
        w_rslt_hi_nxt = r_rslt_hi;
        w_carry_nxt   = r_carry;
        w_branch_nxt  = r_branch;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_op_nxt = ALUOp;
                    if (w_go_busy) begin
                        w_state_nxt  = c_BUSY;
                        w_a_nxt      = inA;
                        w_b_nxt      = inB;
                        w_acc_hi_nxt = '0;
                        w_cnt_nxt    = (ALUOp == c_OP_MUL) ? SW'(W) : w_n;
                    end else begin
                        w_state_nxt   = c_DONE;
                        w_rslt_nxt    = w_sc_rslt;
                        w_rslt_hi_nxt = '0;
                        w_carry_nxt   = w_sc_carry;
                        w_branch_nxt  = w_sc_branch;
                    end
                end
            end
            c_BUSY: begin
                w_cnt_nxt = r_cnt - SW'(1);
                if (r_op == c_OP_MUL) begin
                    w_acc_hi_nxt = w_mul_sum[W:1];
                    w_b_nxt      = {w_mul_sum[0], r_b[W-1:1]};
                end else begin
                    w_a_nxt   = w_step_a;
                    w_shc_nxt = w_step_c;
                end
                // Architectural outputs move only on the final step
                if (r_cnt == SW'(1)) begin
                    w_state_nxt  = c_DONE;
                    w_branch_nxt = 1'b0;
                    if (r_op == c_OP_MUL) begin
                        w_rslt_nxt    = {w_mul_sum[0], r_b[W-1:1]};
                        w_rslt_hi_nxt = w_mul_sum[W:1];
                        w_carry_nxt   = |w_mul_sum[W:1];
                    end else begin
                        w_rslt_nxt    = w_step_a;
                        w_rslt_hi_nxt = '0;
                        w_carry_nxt   = w_step_c;
                    end
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= c_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc_hi  <= '0;
            r_cnt     <= '0;
            r_shc     <= 1'b0;
            r_rslt    <= '0;
            r_rslt_hi <= '0;
            r_carry   <= 1'b0;
            r_branch  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_acc_hi  <= w_acc_hi_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shc     <= w_shc_nxt;
            r_rslt    <= w_rslt_nxt;
            r_rslt_hi <= w_rslt_hi_nxt;
            r_carry   <= w_carry_nxt;
            r_branch  <= w_branch_nxt;
        end
    end

    assign in_ready   = (r_state == c_IDLE);
    assign out_valid  = (r_state == c_DONE);
    assign rslt       = r_rslt;
    assign rslt_hi    = r_rslt_hi;
    assign carry      = r_carry;
    assign branchFlag = r_branch;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (W=8 and W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [3:0]  ALUOp8 = '0;
    logic [7:0]  inA8 = '0, inB8 = '0, rslt8, rslt_hi8;
    logic        carry8, branch8;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
    logic [3:0]  ALUOp16 = '0;
    logic [15:0] inA16 = '0, inB16 = '0, rslt16, rslt_hi16;
    logic        carry16, branch16;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.W(8)) u_dut8 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUOp(ALUOp8), .inA(inA8), .inB(inB8), .out_valid(out_valid8),
        .out_ready(out_ready8), .rslt(rslt8), .rslt_hi(rslt_hi8),
        .carry(carry8), .branchFlag(branch8)
    );

    alu_seq #(.W(16)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .ALUOp(ALUOp16), .inA(inA16), .inB(inB16), .out_valid(out_valid16),
        .out_ready(out_ready16), .rslt(rslt16), .rslt_hi(rslt_hi16),
        .carry(carry16), .branchFlag(branch16)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one op on the W=8 instance; returns with the DUT in DONE, #1 after the edge
    task automatic op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
        bit busy_rdy;
        @(negedge Clk);
        chk("in_ready_before_op", 64'(in_ready8), 64'(1));
        ALUOp8 = op; inA8 = a; inB8 = b; in_valid8 = 1'b1;
        @(posedge Clk); #1;
        in_valid8 = 1'b0; ALUOp8 = 4'hF; inA8 = ~a; inB8 = ~b;
        lat = 1;
        busy_rdy = 1'b0;
        while (!out_valid8 && lat < 40) begin
            if (in_ready8) busy_rdy = 1'b1;
            @(posedge Clk); #1;
            lat++;
        end
        chk("out_valid_seen", 64'(out_valid8), 64'(1));
        chk("in_ready_low_busy_done", 64'({busy_rdy, in_ready8}), 64'(0));
    endtask

    task automatic take8();
        @(negedge Clk);
        out_ready8 = 1'b1;
        @(posedge Clk); #1;
        out_ready8 = 1'b0;
        chk("idle_after_take", 64'({in_ready8, out_valid8}), 64'(2'b10));
    endtask

    task automatic do8(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [7:0] exp_r,
                       input logic [7:0] exp_hi, input logic exp_c, input logic exp_br);
        int lat;
        op8(op, a, b, lat);
        chk({tag, ".lat"},    64'(lat),      64'(exp_lat));
        chk({tag, ".rslt"},   64'(rslt8),    64'(exp_r));
        chk({tag, ".hi"},     64'(rslt_hi8), 64'(exp_hi));
        chk({tag, ".carry"},  64'(carry8),   64'(exp_c));
        chk({tag, ".branch"}, 64'(branch8),  64'(exp_br));
        take8();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst.in_ready",  64'(in_ready8),  64'(1));
        chk("rst.out_valid", 64'(out_valid8), 64'(0));
        chk("rst.outs", 64'({rslt8, rslt_hi8, carry8, branch8}), 64'(0));
        chk("rst16.outs", 64'({rslt16, rslt_hi16, carry16, branch16, out_valid16}), 64'(0));
        Reset = 1'b0;

        // Carry chaining through ADD
        do8("add1", 4'b0101, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 1'b1, 1'b0);
        do8("add2", 4'b0101, 8'h00, 8'h00, 1, 8'h01, 8'h00, 1'b0, 1'b0);
        // Borrow and compares
        do8("sec",  4'b1110, 8'h5A, 8'h00, 1, 8'h5A, 8'h00, 1'b1, 1'b0);
        do8("sub",  4'b0110, 8'h05, 8'h07, 1, 8'hFE, 8'h00, 1'b0, 1'b0);
        do8("lt",   4'b0111, 8'h03, 8'h09, 1, 8'h00, 8'h00, 1'b0, 1'b1);
        do8("gt",   4'b1000, 8'h09, 8'h03, 1, 8'h00, 8'h00, 1'b0, 1'b1);
        do8("eqf",  4'b1001, 8'h05, 8'h06, 1, 8'h00, 8'h00, 1'b0, 1'b0);
        do8("eq",   4'b1001, 8'h05, 8'h05, 1, 8'h00, 8'h00, 1'b0, 1'b1);
        // Multi-cycle shifts, zero count and saturation
        do8("shln3",  4'b1010, 8'hB1, 8'h03, 4, 8'h88, 8'h00, 1'b1, 1'b0);
        do8("shln0",  4'b1010, 8'hB1, 8'h00, 1, 8'hB1, 8'h00, 1'b1, 1'b0);
        do8("clc",    4'b1101, 8'h11, 8'h00, 1, 8'h11, 8'h00, 1'b0, 1'b0);
        do8("shlnF",  4'b1010, 8'hB1, 8'h0F, 9, 8'h00, 8'h00, 1'b1, 1'b0);
        do8("shrn2",  4'b1011, 8'hB1, 8'h02, 3, 8'h2C, 8'h00, 1'b0, 1'b0);
        // Multiply
        do8("mul_small", 4'b1100, 8'h0D, 8'h0B, 9, 8'h8F, 8'h00, 1'b0, 1'b0);
        do8("mul_max",   4'b1100, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1'b1, 1'b0);
        // Single-bit shifts through carry
        do8("shr1", 4'b0100, 8'h81, 8'h00, 1, 8'hC0, 8'h00, 1'b1, 1'b0);
        do8("shl1", 4'b0011, 8'h40, 8'h00, 1, 8'h81, 8'h00, 1'b0, 1'b0);
        do8("or",   4'b0010, 8'hF0, 8'h0C, 1, 8'hFC, 8'h00, 1'b0, 1'b0);

        // Backpressure: result held, no accept until the cycle after out_ready
        op8(4'b0001, 8'hF0, 8'h3C, lat);
        chk("xor.lat",  64'(lat),   64'(1));
        chk("xor.rslt", 64'(rslt8), 64'(8'hCC));
        @(negedge Clk);
        in_valid8 = 1'b1; ALUOp8 = 4'b0000; inA8 = 8'hF0; inB8 = 8'h3C;
        repeat (5) begin
            @(posedge Clk); #1;
            chk("bp.valid", 64'(out_valid8), 64'(1));
            chk("bp.rslt",  64'(rslt8),      64'(8'hCC));
            chk("bp.ready", 64'(in_ready8),  64'(0));
        end
        @(negedge Clk);
        out_ready8 = 1'b1;
        @(posedge Clk); #1;
        out_ready8 = 1'b0;
        chk("bp.exit", 64'({in_ready8, out_valid8}), 64'(2'b10));
        chk("bp.exit_rslt", 64'(rslt8), 64'(8'hCC));
        @(posedge Clk); #1;
        in_valid8 = 1'b0;
        chk("bp.accept_valid", 64'(out_valid8), 64'(1));
        chk("bp.accept_rslt",  64'(rslt8),      64'(8'h30));
        take8();

        // Reset on the 4th BUSY edge of a MUL aborts it
        do8("sec2", 4'b1110, 8'h5A, 8'h00, 1, 8'h5A, 8'h00, 1'b1, 1'b0);
        @(negedge Clk);
        ALUOp8 = 4'b1100; inA8 = 8'hFF; inB8 = 8'hFF; in_valid8 = 1'b1;
        @(posedge Clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("abort.in_ready", 64'(in_ready8), 64'(1));
        chk("abort.outs", 64'({out_valid8, rslt8, rslt_hi8, carry8, branch8}), 64'(0));
        seen = 1'b0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        chk("abort.no_valid", 64'(seen), 64'(0));

        // W=16 multiply
        @(negedge Clk);
        ALUOp16 = 4'b1100; inA16 = 16'hFFFF; inB16 = 16'hFFFF; in_valid16 = 1'b1;
        @(posedge Clk); #1;
        in_valid16 = 1'b0; inA16 = 16'h0; inB16 = 16'h0;
        lat = 1;
        while (!out_valid16 && lat < 60) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk("mul16.lat",   64'(lat), 64'(17));
        chk("mul16.prod",  64'({rslt_hi16, rslt16}), 64'(32'hFFFE0001));
        chk("mul16.carry", 64'(carry16), 64'(1));
        @(negedge Clk);
        out_ready16 = 1'b1;
        @(posedge Clk); #1;
        out_ready16 = 1'b0;
        chk("mul16.idle", 64'({in_ready16, out_valid16}), 64'(2'b10));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the datapath ALU. It keeps the existing 4-bit opcode map for logic, add/sub, single-bit shifts and compares. It adds a generic data width, an internal carry flag register, registered outputs with a valid/ready handshake, and iterative multi-cycle ops: shift-by-N and an unsigned W×W multiply. It sits between the register file read ports and the writeback/branch logic of the core; the controller stalls on `in_ready`/`out_valid`.

## Interface
- `W`, 8: datapath width in bits (≥2).
- `SW`, $clog2(W)+1: width of shift-count field taken from `inB[SW-1:0]`; counts 0..W are legal, counts >W saturate to W.
- `Clk`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `ALUOp`  in  4  opcode, sampled at acceptance.
- `inA`, `inB`  in  W each  operands, sampled at acceptance.
- `out_valid`  out  1  result registers valid; high only in DONE.
- `out_ready`  in  1  consumer takes the result.
- `rslt`  out  W  registered result.
- `rslt_hi`  out  W  upper product half (MUL only, else 0).
- `carry`  out  1  internal carry flag (registered, persistent across ops).
- `branchFlag`  out  1  registered compare result.

## Operation
- Acceptance = `in_valid & in_ready` at a rising edge. Operands and opcode are latched; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→DONE: single-cycle op.
  - IDLE→BUSY: multi-cycle op with count>0.
  - BUSY→DONE: when step counter reaches 0.
  - DONE→IDLE: when `out_ready`=1.
- `in_ready` is low in BUSY and DONE, so there is no same-cycle accept on the DONE exit.
- Single-cycle ops; `c` is the current carry flag:
  - 0000 AND, 0001 XOR, 0010 OR.
  - 0011 SHL1: {carry,rslt} = {A,c}.
  - 0100 SHR1: {rslt,carry} = {c,A}.
  - 0101 ADD: {carry,rslt} = A+B+c, W+1-bit sum.
  - 0110 SUB: {carry,rslt} = A+~B+c, W+1-bit sum. Carry=1 means no borrow; A−B therefore requires c=1 beforehand.
  - 0111 LT, 1000 GT, 1001 EQ: unsigned compare; branchFlag=1 if true; rslt=0; carry unchanged.
  - 1101 CLC: carry=0. 1110 SEC: carry=1. For both, rslt=A.
  - 1111 and all unlisted codes: rslt=A; carry unchanged.
- For every non-compare op, branchFlag=0. Carry is unchanged by AND/XOR/OR.
- Multi-cycle ops (n = min(inB[SW-1:0], W)):
  - 1010 SHLN: one left shift per BUSY edge. Zero fill; carry takes each shifted-out MSB.
  - 1011 SHRN: the same, shifting right; carry takes each shifted-out LSB.
  - n=0 on either shift: treated as single-cycle; rslt=A, carry unchanged.
  - 1100 MUL: unsigned shift-add over exactly W BUSY edges. {rslt_hi,rslt} = A×B (2W bits). carry = (rslt_hi≠0). Carry-in is ignored.
- rslt_hi=0 for all ops except MUL.
- Result registers and `branchFlag` hold their values through DONE and IDLE until the next op completes. Carry persists until changed by an op or by reset.

## Timing
- Reset: state IDLE, `in_ready`=1.
- Reset values: `out_valid`=0, `rslt`=0, `rslt_hi`=0, `carry`=0, `branchFlag`=0, step counter 0.
- Reset in BUSY or DONE aborts the op. The pending result is discarded and `out_valid` is never raised for it.
- Reset overrides `in_valid` in the same cycle.
- Latency is measured from the acceptance edge to the first edge where `out_valid`=1:
  - single-cycle ops: 1 edge.
  - SHLN/SHRN: n+1 edges.
  - MUL: W+1 edges.
- `out_valid` stays high until `out_ready` is sampled high. The state is IDLE on the following cycle, so peak throughput is one single-cycle op per 2 cycles.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- The carry output changes only on the edge that enters DONE (or on reset), never mid-BUSY. Intermediate shift carries stay internal.

## Test plan
- Reset, then ADD A=8'hFF, B=8'h01 with carry=0 → out_valid 1 edge after accept; rslt=8'h00, carry=1. A following ADD A=8'h00, B=8'h00 → rslt=8'h01 (carry chained), carry=0.
- SEC, then SUB A=8'h05, B=8'h07 → rslt=8'hFE, carry=0 (borrow). Then LT A=3, B=9 → branchFlag=1, rslt=0, carry still 0.
- SHLN A=8'b1011_0001, B=3 → out_valid exactly 4 edges after accept, rslt=8'b1000_1000, carry=1. In the same run, B=0 → rslt=A after 1 edge, carry unchanged. B=8'h0F saturates to 8 → rslt=0.
- MUL A=8'hFF, B=8'hFF → out_valid 9 edges after accept; rslt_hi=8'hFE, rslt=8'h01, carry=1. in_ready stays low throughout BUSY and DONE.
- Backpressure: hold out_ready=0 for 5 cycles after a completed XOR → rslt and out_valid stable; a second in_valid is not accepted until the cycle after out_ready=1.
- Reset asserted on the 4th BUSY edge of a MUL → next cycle IDLE, all outputs 0, no out_valid pulse. A subsequent W=16 instance repeats MUL with A=B=16'hFFFF → {rslt_hi,rslt}=32'hFFFE0001, 17-edge latency.
